// File: rtl/rv_multicycle_core.sv
// rtl/rv_multicycle_core.sv - multicycle RV32I/RV32E execution core (FETCH_INSTR/FETCH_REGS/EXECUTE/HALT)
// Optional RV_CONTROL_FLOW_EN adds LUI, AUIPC, JAL, JALR and conditional branches.
module rv_multicycle_core #(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [XLEN-1:0]   dbg_data,
  output logic [3:0]        state_o,
  output logic              halted,
  output logic              illegal
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("rv_multicycle_core: XLEN must be 32");
  end
  if (NREGS != 32 && NREGS != 16) begin : g_nregs_chk
    $error("rv_multicycle_core: NREGS must be 32 or 16");
  end
  if (RESET_ADDR[1:0] != 2'b00) begin : g_reset_addr_chk
    $error("rv_multicycle_core: RESET_ADDR must be word-aligned");
  end

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_REGS  = 4'b0010,
    S_EXEC  = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  localparam logic [31:0] NOP    = 32'h0000_0033;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0]  OP_REG = 7'b0110011;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_SYS = 7'b1110011;
`ifdef RV_CONTROL_FLOW_EN
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
`endif
  localparam logic RV32E = (NREGS == 16);

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc, rs1, rs2;
  logic [31:0]       instr;
  // Always 32 entries; in RV32E the upper half is never written and reads as zero.
  logic [XLEN-1:0]   regs [32];

  logic [6:0]        opcode, f7;
  logic [4:0]        rd, shamt;
  logic [2:0]        f3;
  logic [XLEN-1:0]   iimm, alu_b, alu_y, nxt_pc, wb_val;
  logic              wb_en, trap, brk, use_rs1, use_rs2, use_rd;
`ifdef RV_CONTROL_FLOW_EN
  logic [XLEN-1:0]   bimm, jimm, uimm, target;
  logic              taken;
`endif

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign iimm   = {{20{instr[31]}}, instr[31:20]};
  assign alu_b  = (opcode == OP_REG) ? rs2 : iimm;
  assign shamt  = alu_b[4:0];
`ifdef RV_CONTROL_FLOW_EN
  assign bimm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign jimm   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign uimm   = {instr[31:12], 12'b0};
`endif

  // Reset pulls the request low asynchronously so a pending fetch is abandoned at once.
  assign imem_req  = (state == S_FETCH) && resetn;
  assign imem_addr = pc[ADDR_W-1:0];
  assign state_o   = state;
  assign dbg_data  = (dbg_sel == 5'd0 || (RV32E && dbg_sel[4])) ? '0 : regs[dbg_sel];

  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000: alu_y = (opcode == OP_REG && f7[5]) ? rs1 - alu_b : rs1 + alu_b;
      3'b001: alu_y = rs1 << shamt;
      3'b010: alu_y = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(alu_b)};
      3'b011: alu_y = {{(XLEN-1){1'b0}}, rs1 < alu_b};
      3'b100: alu_y = rs1 ^ alu_b;
      3'b101: begin
        if (f7[5]) alu_y = $signed(rs1) >>> shamt;
        else       alu_y = rs1 >> shamt;
      end
      3'b110: alu_y = rs1 | alu_b;
      default: alu_y = rs1 & alu_b;
    endcase
  end

  always_comb begin
    nxt_pc  = pc + 32'd4;
    wb_en   = 1'b0;
    wb_val  = alu_y;
    trap    = 1'b0;
    brk     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
`ifdef RV_CONTROL_FLOW_EN
    target  = '0;
    taken   = 1'b0;
`endif
    case (opcode)
      OP_REG: begin
        {use_rs1, use_rs2, use_rd, wb_en} = 4'b1111;
        if (f7 != 7'h00 && f7 != 7'h20) trap = 1'b1;
        if (f7[5] && f3 != 3'b000 && f3 != 3'b101) trap = 1'b1;
      end
      OP_IMM: begin
        {use_rs1, use_rd, wb_en} = 3'b111;
        if (f3 == 3'b001 && f7 != 7'h00) trap = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) trap = 1'b1;
      end
      OP_SYS: begin
        if (instr == EBREAK) brk = 1'b1;
        else                 trap = 1'b1;
      end
`ifdef RV_CONTROL_FLOW_EN
      OP_LUI: begin
        {use_rd, wb_en} = 2'b11;
        wb_val = uimm;
      end
      OP_AUIPC: begin
        {use_rd, wb_en} = 2'b11;
        wb_val = pc + uimm;
      end
      OP_JAL: begin
        {use_rd, wb_en} = 2'b11;
        wb_val = pc + 32'd4;
        target = pc + jimm;
        nxt_pc = target;
        if (target[1]) trap = 1'b1;
      end
      OP_JALR: begin
        {use_rs1, use_rd, wb_en} = 3'b111;
        wb_val = pc + 32'd4;
        target = (rs1 + iimm) & ~32'd1;
        nxt_pc = target;
        if (target[1] || f3 != 3'b000) trap = 1'b1;
      end
      OP_BR: begin
        {use_rs1, use_rs2} = 2'b11;
        case (f3)
          3'b000:  taken = (rs1 == rs2);
          3'b001:  taken = (rs1 != rs2);
          3'b100:  taken = ($signed(rs1) < $signed(rs2));
          3'b101:  taken = ($signed(rs1) >= $signed(rs2));
          3'b110:  taken = (rs1 < rs2);
          3'b111:  taken = (rs1 >= rs2);
          default: trap  = 1'b1;
        endcase
        target = pc + bimm;
        if (taken) begin
          nxt_pc = target;
          if (target[1]) trap = 1'b1;
        end
      end
`endif
      default: trap = 1'b1;
    endcase
    if (RV32E && ((use_rs1 && instr[19]) || (use_rs2 && instr[24]) || (use_rd && instr[11])))
      trap = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: if (imem_req && imem_ready) state_nx = S_REGS;
      S_REGS:  state_nx = S_EXEC;
      S_EXEC:  state_nx = (trap || brk) ? S_HALT : S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_FETCH;
      pc      <= RESET_ADDR;
      instr   <= NOP;
      rs1     <= '0;
      rs2     <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (imem_req && imem_ready) instr <= imem_rdata;
        S_REGS: begin
          rs1 <= regs[instr[19:15]];
          rs2 <= regs[instr[24:20]];
        end
        S_EXEC: begin
          if (brk) halted <= 1'b1;
          else if (trap) illegal <= 1'b1;
          else begin
            pc <= nxt_pc;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb/tb_rv_multicycle_core.sv - self-checking bench for rv_multicycle_core (vector table, hand sequences, random programs vs ISA model)
module tb_rv_multicycle_core;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata, dbg_data;
  logic [4:0]  dbg_sel = 5'd0;
  logic [3:0]  state_o;
  logic        halted, illegal;

  logic        imem_req_e, halted_e, illegal_e;
  logic        imem_ready_e = 1'b1;
  logic [15:0] imem_addr_e;
  logic [31:0] imem_rdata_e, dbg_data_e;
  logic [4:0]  dbg_sel_e = 5'd0;
  logic [3:0]  state_e;

  logic [31:0] prog   [64];
  logic [31:0] prog_e [64];
  logic [31:0] trace  [64];
  int          wait_cfg = 0;
  int          wcnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] iss_regs [32];
  logic [31:0] iss_pc;
  logic        iss_halt, iss_ill;
  int          iss_n;

  rv_multicycle_core #(.XLEN(32), .NREGS(32), .ADDR_W(16), .RESET_ADDR(32'h0)) u_dut (
    .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .state_o(state_o), .halted(halted), .illegal(illegal));

  rv_multicycle_core #(.XLEN(32), .NREGS(16), .ADDR_W(16), .RESET_ADDR(32'h0)) u_dut_e (
    .clk(clk), .resetn(resetn), .imem_req(imem_req_e), .imem_addr(imem_addr_e),
    .imem_ready(imem_ready_e), .imem_rdata(imem_rdata_e), .dbg_sel(dbg_sel_e),
    .dbg_data(dbg_data_e), .state_o(state_e), .halted(halted_e), .illegal(illegal_e));

  always #5 clk = ~clk;

  // Instruction memory: ready is withheld for wait_cfg cycles of every fetch.
  assign imem_ready   = imem_req && (wcnt >= wait_cfg);
  assign imem_rdata   = prog[imem_addr[7:2]];
  assign imem_rdata_e = prog_e[imem_addr_e[7:2]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) wcnt <= 0;
    else if (imem_req) wcnt <= imem_ready ? 0 : wcnt + 1;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    dbg_sel = idx[4:0];
    #1;
    v = dbg_data;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = EBREAK;
  endtask

  // Resets the core, runs until HALT and returns the clk edges from reset release to HALT entry.
  task automatic run_prog(input int wcfg, output int cyc, output int viol);
    logic        pw;
    logic [15:0] pa;
    wait_cfg = wcfg;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0; viol = 0; pw = 1'b0; pa = '0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) trace[cyc] = dbg_data;
      if (pw && imem_req && imem_addr !== pa) viol++;
      pw = imem_req && !imem_ready;
      pa = imem_addr;
      if (state_o == 4'b1000) break;
    end
    chk("halt_reached", {28'b0, state_o}, 32'h8);
  endtask

  // Architectural reference: executes the program one instruction at a time from the ISA rules.
  task automatic iss_run();
    logic [31:0] w, a, b, res;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        ok;
    for (int i = 0; i < 32; i++) iss_regs[i] = 32'h0;
    iss_pc = 0; iss_halt = 0; iss_ill = 0; iss_n = 0;
    while (!iss_halt && !iss_ill && iss_n < 500) begin
      w  = prog[iss_pc[7:2]];
      iss_n++;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      a  = iss_regs[w[19:15]];
      if (w == EBREAK) iss_halt = 1;
      else if (op == 7'h33 || op == 7'h13) begin
        b = (op == 7'h33) ? iss_regs[w[24:20]] : {{20{w[31]}}, w[31:20]};
        if (op == 7'h33)  ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        else if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
        else              ok = 1;
        if (!ok) iss_ill = 1;
        else begin
          case (f3)
            3'd0: res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
              if (f7 == 7'h20) res = $signed(a) >>> b[4:0];
              else             res = a >> b[4:0];
            end
            3'd6: res = a | b;
            default: res = a & b;
          endcase
          if (w[11:7] != 0) iss_regs[w[11:7]] = res;
          iss_pc = iss_pc + 4;
        end
      end else iss_ill = 1;
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        exp_ill;
  } vec_t;

  vec_t vt [22];

  initial begin
    int          cyc, viol;
    logic [31:0] v, acc;

    // x2 = 0xFFFFFFFB and x1 = 4 ahead of each vector
    vt[0]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd3),  5'd3,  32'h0000_0000, 1'b0};
    vt[1]  = '{enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd4),  5'd4,  32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd5, 5'd4),  5'd4,  32'h0FFF_FFFF, 1'b0};
    vt[3]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5),  5'd5,  32'h0000_0009, 1'b0};
    vt[4]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd6),  5'd6,  32'h0000_0001, 1'b0};
    vt[5]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd1, 5'd7),  5'd7,  32'hFFFF_FFB0, 1'b0};
    vt[6]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd8),  5'd8,  32'hFFFF_FFFF, 1'b0};
    vt[7]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd7, 5'd9),  5'd9,  32'h0000_0000, 1'b0};
    vt[8]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd6, 5'd10), 5'd10, 32'hFFFF_FFFF, 1'b0};
    vt[9]  = '{enc_i(12'd7,   5'd0, 3'd0, 5'd0),      5'd0,  32'h0000_0000, 1'b0};
    vt[10] = '{enc_i(12'd31,  5'd2, 3'd1, 5'd11),     5'd11, 32'h8000_0000, 1'b0};
    vt[11] = '{enc_i(12'h401, 5'd2, 3'd5, 5'd12),     5'd12, 32'hFFFF_FFFD, 1'b0};
    vt[12] = '{enc_i(12'hFFF, 5'd1, 3'd3, 5'd13),     5'd13, 32'h0000_0001, 1'b0};
    vt[13] = '{enc_i(12'hFFC, 5'd2, 3'd2, 5'd14),     5'd14, 32'h0000_0001, 1'b0};
    vt[14] = '{enc_i(12'h7F0, 5'd2, 3'd7, 5'd15),     5'd15, 32'h0000_07F0, 1'b0};
    vt[15] = '{enc_r(7'h00, 5'd2, 5'd2, 3'd0, 5'd31), 5'd31, 32'hFFFF_FFF6, 1'b0};
    vt[16] = '{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3),  5'd3,  32'h0, 1'b1};
    vt[17] = '{enc_r(7'h20, 5'd1, 5'd2, 3'd1, 5'd3),  5'd3,  32'h0, 1'b1};
    vt[18] = '{32'h0000_0000,                         5'd0,  32'h0, 1'b1};
    vt[19] = '{32'h0000_0073,                         5'd0,  32'h0, 1'b1};
    vt[20] = '{enc_i(12'h401, 5'd2, 3'd1, 5'd3),      5'd3,  32'h0, 1'b1};
    vt[21] = '{32'h0000_000B,                         5'd0,  32'h0, 1'b1};

    clear_prog();
    for (int i = 0; i < 64; i++) prog_e[i] = EBREAK;
    prog_e[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    prog_e[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd17);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_state", {28'b0, state_o}, 32'h1);
    chk("rst_addr", {16'b0, imem_addr}, 32'h0);
    chk("rst_flags", {30'b0, halted, illegal}, 32'h0);

    // counting program, zero-wait
    prog[0] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
    for (int i = 1; i <= 4; i++) prog[i] = enc_i(12'd1, 5'd1, 3'd0, 5'd1);
    prog[5] = EBREAK;
    dbg_sel = 5'd1;
    run_prog(0, cyc, viol);
    chk("p1_cycles", cyc, 32'd18);
    chk("p1_dbg_old_during_wb", trace[14], 32'd3);
    chk("p1_dbg_after_wb", trace[15], 32'd4);
    rd_reg(1, v);
    chk("p1_x1", v, 32'd4);
    chk("p1_flags", {30'b0, halted, illegal}, 32'h2);
    chk("p1_pc", {16'b0, imem_addr}, 32'h14);
    chk("p1_imem_req", {31'b0, imem_req}, 32'h0);

    // RV32E instance ran addi x1,x0,5; addi x17,x0,1 in parallel
    chk("e_state", {28'b0, state_e}, 32'h8);
    chk("e_flags", {30'b0, halted_e, illegal_e}, 32'h1);
    chk("e_imem_req", {31'b0, imem_req_e}, 32'h0);
    chk("e_pc", {16'b0, imem_addr_e}, 32'h4);
    dbg_sel_e = 5'd1; #1;
    chk("e_x1", dbg_data_e, 32'd5);
    dbg_sel_e = 5'd17; #1;
    chk("e_x17", dbg_data_e, 32'd0);
    acc = 0;
    for (int r = 2; r < 16; r++) begin
      dbg_sel_e = r[4:0]; #1;
      acc |= dbg_data_e;
    end
    chk("e_x2_x15", acc, 32'h0);

    // same program, three wait states per fetch
    run_prog(3, cyc, viol);
    chk("p2_cycles", cyc, 32'd36);
    chk("p2_addr_stable_viol", viol, 32'd0);
    rd_reg(1, v);
    chk("p2_x1", v, 32'd4);
    chk("p2_flags", {30'b0, halted, illegal}, 32'h2);
    chk("p2_pc", {16'b0, imem_addr}, 32'h14);

    // single-instruction vectors
    for (int i = 0; i < 22; i++) begin
      clear_prog();
      prog[0] = enc_i(12'hFFB, 5'd0, 3'd0, 5'd2);
      prog[1] = enc_i(12'd4, 5'd0, 3'd0, 5'd1);
      prog[2] = vt[i].instr;
      run_prog(0, cyc, viol);
      if (vt[i].exp_ill) begin
        chk($sformatf("vec%0d_flags", i), {30'b0, halted, illegal}, 32'h1);
        chk($sformatf("vec%0d_pc", i), {16'b0, imem_addr}, 32'h8);
        chk($sformatf("vec%0d_cycles", i), cyc, 32'd9);
      end else begin
        chk($sformatf("vec%0d_flags", i), {30'b0, halted, illegal}, 32'h2);
        rd_reg(vt[i].rd, v);
        chk($sformatf("vec%0d_rd", i), v, vt[i].exp);
        chk($sformatf("vec%0d_cycles", i), cyc, 32'd12);
      end
    end

    // bne loop
    clear_prog();
    prog[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd5);
    prog[1] = enc_i(12'd1, 5'd1, 3'd0, 5'd1);
    prog[2] = enc_b(13'h1FFC, 5'd5, 5'd1, 3'b001);
    run_prog(0, cyc, viol);
    rd_reg(1, v);
`ifdef RV_CONTROL_FLOW_EN
    chk("bne_x1", v, 32'd3);
    chk("bne_flags", {30'b0, halted, illegal}, 32'h2);
    chk("bne_pc", {16'b0, imem_addr}, 32'hC);
    chk("bne_cycles", cyc, 32'd24);
`else
    chk("bne_x1", v, 32'd1);
    chk("bne_flags", {30'b0, halted, illegal}, 32'h1);
    chk("bne_pc", {16'b0, imem_addr}, 32'h8);
    chk("bne_cycles", cyc, 32'd9);
`endif

    // reset asserted while a fetch is stalled
    clear_prog();
    prog[0] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
    for (int i = 1; i <= 4; i++) prog[i] = enc_i(12'd1, 5'd1, 3'd0, 5'd1);
    wait_cfg = 0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    wait_cfg = 1000;
    repeat (2) @(posedge clk);
    #1;
    chk("mr_stalled_state", {28'b0, state_o}, 32'h1);
    chk("mr_stalled_req", {31'b0, imem_req}, 32'h1);
    chk("mr_stalled_addr", {16'b0, imem_addr}, 32'h8);
    rd_reg(1, v);
    chk("mr_x1_before", v, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mr_req_drop", {31'b0, imem_req}, 32'h0);
    chk("mr_state", {28'b0, state_o}, 32'h1);
    chk("mr_pc", {16'b0, imem_addr}, 32'h0);
    acc = 0;
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, v);
      acc |= v;
    end
    chk("mr_regs_zero", acc, 32'h0);
    wait_cfg = 0;

    // random ALU programs against the reference model
    for (int t = 0; t < 12; t++) begin
      int          wc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
      int          sel;
      clear_prog();
      for (int i = 0; i < 20; i++) begin
        sel = $urandom_range(0, 99);
        f3  = 3'($urandom_range(0, 7));
        if (sel < 45) begin
          imm = 12'($urandom);
          if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
          if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
          prog[i] = enc_i(imm, 5'($urandom), f3, 5'($urandom));
        end else if (sel < 97) begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          if (sel >= 92) f7 = 7'($urandom);
          prog[i] = enc_r(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom));
        end else begin
          prog[i] = 32'hFFFF_FFFF;
        end
      end
      wc = $urandom_range(0, 2);
      iss_run();
      run_prog(wc, cyc, viol);
      chk($sformatf("rnd%0d_cycles", t), cyc, iss_n * (3 + wc));
      chk($sformatf("rnd%0d_flags", t), {30'b0, halted, illegal}, {30'b0, iss_halt, iss_ill});
      chk($sformatf("rnd%0d_pc", t), {16'b0, imem_addr}, {16'b0, iss_pc[15:0]});
      for (int r = 1; r < 32; r++) begin
        rd_reg(r, v);
        chk($sformatf("rnd%0d_x%0d", t, r), v, iss_regs[r]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
